// File: rtl/eth_ping_responder_if.sv
// Byte-wide AXI4-Stream bundle used for the MAC RX and TX sides of eth_ping_responder.
interface eth_ping_responder_if #(
    parameter int USER_W = 1
);
    logic [7:0]        tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/eth_ping_responder.sv
// Far-end ping responder: captures ping requests from the MAC RX stream and echoes a reply on TX.
// Define ETH_PING_RESPONDER_STATS_EN to build the rx/tx/drop statistics counters.
module eth_ping_responder #(
    parameter int          C_MAX_FRAME = 128,
    parameter logic [15:0] C_ETHERTYPE = 16'h4C54,
    parameter logic [47:0] C_LOCAL_MAC = 48'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    eth_ping_responder_if.slave  s_axis,
    eth_ping_responder_if.master m_axis,
    output logic [31:0]          rx_count,
    output logic [31:0]          tx_count,
    output logic [31:0]          drop_count
);
    localparam int          AW      = $clog2(C_MAX_FRAME);
    localparam logic [12:0] MAX_LEN = 13'(C_MAX_FRAME);

    typedef enum logic [1:0] {R_IDLE, R_CAP, R_SKIP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_SEND} tx_state_t;

    rx_state_t rx_state, rx_state_nxt;
    tx_state_t tx_state, tx_state_nxt;

    logic [7:0]    frame_buf [C_MAX_FRAME];
    logic [7:0]    rd_data;
    logic [AW-1:0] rd_addr;
    logic          rd_en, wr_en;

    logic [12:0] rx_idx, byte_idx, len;
    logic        eth_hi_ok, etype_ok, op_ok, skip_cnt, skip_cnt_nxt;
    logic        hi_now, match_now, op_now;
    logic        beat, accept, drop_inc;

    logic [12:0] tx_idx, tx_idx_nxt, rd_idx;
    logic        tx_valid, tx_valid_nxt, tx_last, tx_last_nxt, tx_done;
    logic [7:0]  tx_data;

    function automatic logic [7:0] mac_byte(input logic [2:0] k);
        logic [47:0] sh;
        sh = C_LOCAL_MAC >> {3'd5 - k, 3'b000};
        return sh[7:0];
    endfunction

    // Match flags are evaluated on the byte being received so tlast on byte 13/14 still qualifies
    assign beat      = s_axis.tvalid;
    assign byte_idx  = (rx_state == R_IDLE) ? 13'd0 : rx_idx;
    assign hi_now    = (byte_idx == 13'd12) && (s_axis.tdata == C_ETHERTYPE[15:8]);
    assign match_now = (byte_idx == 13'd13) ? (eth_hi_ok && (s_axis.tdata == C_ETHERTYPE[7:0])) : etype_ok;
    assign op_now    = (byte_idx == 13'd14) ? (s_axis.tdata == 8'h01) : op_ok;

    always_comb begin
        rx_state_nxt = rx_state;
        skip_cnt_nxt = skip_cnt;
        wr_en        = 1'b0;
        accept       = 1'b0;
        drop_inc     = 1'b0;
        case (rx_state)
            R_IDLE: if (beat) begin
                if (!enable || (tx_state != T_IDLE)) begin
                    skip_cnt_nxt = enable;
                    rx_state_nxt = s_axis.tlast ? R_IDLE : R_SKIP;
                end else begin
                    wr_en        = 1'b1;
                    rx_state_nxt = s_axis.tlast ? R_IDLE : R_CAP;
                end
            end
            R_CAP: if (beat) begin
                if (byte_idx >= MAX_LEN) begin
                    skip_cnt_nxt = 1'b1;
                    drop_inc     = s_axis.tlast && match_now;
                    rx_state_nxt = s_axis.tlast ? R_IDLE : R_SKIP;
                end else begin
                    wr_en = 1'b1;
                    if (s_axis.tlast) begin
                        accept       = match_now && op_now && (byte_idx >= 13'd14) && !s_axis.tuser[0];
                        drop_inc     = match_now && !accept;
                        rx_state_nxt = R_IDLE;
                    end
                end
            end
            R_SKIP: if (beat && s_axis.tlast) begin
                drop_inc     = skip_cnt && match_now;
                rx_state_nxt = R_IDLE;
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= R_IDLE;
            rx_idx    <= 13'd0;
            eth_hi_ok <= 1'b0;
            etype_ok  <= 1'b0;
            op_ok     <= 1'b0;
            skip_cnt  <= 1'b0;
            len       <= 13'd0;
        end else begin
            rx_state <= rx_state_nxt;
            skip_cnt <= skip_cnt_nxt;
            if (beat) begin
                rx_idx <= (byte_idx == 13'h1FFF) ? byte_idx : byte_idx + 13'd1;
                if (byte_idx == 13'd0) begin
                    eth_hi_ok <= 1'b0;
                    etype_ok  <= 1'b0;
                    op_ok     <= 1'b0;
                end
                if (byte_idx == 13'd12) eth_hi_ok <= hi_now;
                if (byte_idx == 13'd13) etype_ok  <= match_now;
                if (byte_idx == 13'd14) op_ok     <= op_now;
            end
            if (accept) len <= byte_idx + 13'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) frame_buf[byte_idx[AW-1:0]] <= s_axis.tdata;
        if (rd_en) rd_data <= frame_buf[rd_addr];
    end

    // Read address runs one byte ahead of the output; the first six reply bytes come from the source MAC
    assign rd_idx  = (tx_idx_nxt < 13'd6) ? tx_idx_nxt + 13'd6 : tx_idx_nxt;
    assign rd_addr = rd_idx[AW-1:0];

    always_comb begin
        tx_state_nxt = tx_state;
        tx_idx_nxt   = tx_idx;
        tx_valid_nxt = tx_valid;
        tx_last_nxt  = tx_last;
        rd_en        = 1'b0;
        tx_done      = 1'b0;
        case (tx_state)
            T_IDLE: if (accept) begin
                tx_idx_nxt   = 13'd0;
                tx_state_nxt = T_LOAD;
            end
            T_LOAD: begin
                rd_en        = 1'b1;
                tx_valid_nxt = 1'b1;
                tx_last_nxt  = (tx_idx == len - 13'd1);
                tx_state_nxt = T_SEND;
            end
            T_SEND: if (m_axis.tready) begin
                if (tx_last) begin
                    tx_done      = 1'b1;
                    tx_valid_nxt = 1'b0;
                    tx_last_nxt  = 1'b0;
                    tx_state_nxt = T_IDLE;
                end else begin
                    tx_idx_nxt  = tx_idx + 13'd1;
                    rd_en       = 1'b1;
                    tx_last_nxt = (tx_idx_nxt == len - 13'd1);
                end
            end
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_idx   <= 13'd0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_valid <= tx_valid_nxt;
            tx_last  <= tx_last_nxt;
        end
    end

    always_comb begin
        tx_data = 8'h00;
        if (tx_valid) begin
            if ((tx_idx >= 13'd6) && (tx_idx < 13'd12)) tx_data = mac_byte(3'(tx_idx - 13'd6));
            else if (tx_idx == 13'd14)                  tx_data = 8'h02;
            else                                        tx_data = rd_data;
        end
    end

    assign m_axis.tdata  = tx_data;
    assign m_axis.tvalid = tx_valid;
    assign m_axis.tlast  = tx_last;
    assign m_axis.tuser  = '0;
    assign s_axis.tready = 1'b1;

    logic unused_rx_user;
    assign unused_rx_user = ^s_axis.tuser[2:1];

`ifdef ETH_PING_RESPONDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_count   <= 32'd0;
            tx_count   <= 32'd0;
            drop_count <= 32'd0;
        end else begin
            if (accept)   rx_count   <= rx_count + 32'd1;
            if (tx_done)  tx_count   <= tx_count + 32'd1;
            if (drop_inc) drop_count <= drop_count + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = tx_done ^ drop_inc;
    assign rx_count     = 32'd0;
    assign tx_count     = 32'd0;
    assign drop_count   = 32'd0;
`endif
endmodule

// File: tb/tb_eth_ping_responder.sv
// Self-checking bench for eth_ping_responder: random frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_eth_ping_responder;
    localparam int          C_MAX_FRAME = 128;
    localparam logic [15:0] C_ETHERTYPE = 16'h4C54;
    localparam logic [47:0] C_LOCAL_MAC = 48'h0A1B2C3D4E5F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] rx_count, tx_count, drop_count;

    eth_ping_responder_if #(.USER_W(3)) s_axis ();
    eth_ping_responder_if #(.USER_W(1)) m_axis ();

    eth_ping_responder #(
        .C_MAX_FRAME(C_MAX_FRAME),
        .C_ETHERTYPE(C_ETHERTYPE),
        .C_LOCAL_MAC(C_LOCAL_MAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .s_axis(s_axis),
        .m_axis(m_axis),
        .rx_count(rx_count),
        .tx_count(tx_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tready_mode = 0;
    int tlast_cyc = 0;
    int first_valid_cyc = -1;
    int got_frames = 0;
    int exp_frames = 0;
    int m_rx = 0, m_tx = 0, m_drop = 0;

    logic [7:0] frm[$];
    logic       frm_bad;
    logic [7:0] exp_reply[$];
    logic [7:0] got[$];
    logic       got_last[$];

    always @(posedge clk) cyc <= cyc + 1;

    // tready pattern: 0 = always ready, 1 = random, otherwise held low
    always @(posedge clk) begin
        #1;
        case (tready_mode)
            0:       m_axis.tready = 1'b1;
            1:       m_axis.tready = 1'($urandom_range(0, 1));
            default: m_axis.tready = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic       prev_stall = 1'b0;
    logic [9:0] prev_out = '0;
    bit         in_frame = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            in_frame   = 1'b0;
        end else begin
            if (prev_stall)
                checkOutput("stall_hold", {22'd0, m_axis.tvalid, m_axis.tlast, m_axis.tdata}, {22'd0, prev_out});
            if (in_frame)
                checkOutput("valid_mid_frame", {31'd0, m_axis.tvalid}, 32'd1);
            if (m_axis.tvalid && !in_frame) begin
                in_frame = 1'b1;
                first_valid_cyc = cyc;
            end
            if (m_axis.tvalid && m_axis.tready) begin
                got.push_back(m_axis.tdata);
                got_last.push_back(m_axis.tlast);
                if (m_axis.tlast) begin
                    got_frames++;
                    in_frame = 1'b0;
                end
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_out   = {m_axis.tvalid, m_axis.tlast, m_axis.tdata};
        end
    end

    task automatic buildFrame(input int len, input logic [15:0] et, input logic [7:0] op, input logic [47:0] src);
        logic [7:0] b;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6)       b = 8'hAA;
            else if (i < 12) b = 8'(src >> (8 * (11 - i)));
            else if (i == 12) b = et[15:8];
            else if (i == 13) b = et[7:0];
            else if (i == 14) b = op;
            else             b = 8'($urandom);
            frm.push_back(b);
        end
    endtask

    // Frame-level reference: decides acceptance from the whole frame and builds the expected reply
    task automatic modelFrame(input bit en, input bit busy, output bit acc);
        bit ping;
        int n;
        n    = frm.size();
        ping = (n >= 14) && (frm[12] == 8'h4C) && (frm[13] == 8'h54);
        acc  = en && !busy && ping && (n >= 15) && (n <= C_MAX_FRAME) && (frm[14] == 8'h01) && !frm_bad;
        if (acc) begin
            m_rx++;
            exp_frames++;
            exp_reply.delete();
            for (int j = 0; j < n; j++) begin
                if (j < 6)        exp_reply.push_back(frm[6 + j]);
                else if (j < 12)  exp_reply.push_back(8'(C_LOCAL_MAC >> (8 * (11 - j))));
                else if (j == 14) exp_reply.push_back(8'h02);
                else              exp_reply.push_back(frm[j]);
            end
        end else if (ping && en) begin
            m_drop++;
        end
    endtask

    task automatic applyStimulus(input bit gaps);
        for (int i = 0; i < frm.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    s_axis.tvalid = 1'b0;
                end
            end
            @(posedge clk); #1;
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = frm[i];
            s_axis.tlast  = (i == frm.size() - 1);
            s_axis.tuser  = {2'($urandom_range(0, 3)), s_axis.tlast ? frm_bad : 1'($urandom_range(0, 1))};
            if (s_axis.tlast) tlast_cyc = cyc;
        end
        @(posedge clk); #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic checkCounters(input string tag);
`ifdef ETH_PING_RESPONDER_STATS_EN
        checkOutput({tag, "_rx_count"}, rx_count, m_rx);
        checkOutput({tag, "_tx_count"}, tx_count, m_tx);
        checkOutput({tag, "_drop_count"}, drop_count, m_drop);
`else
        checkOutput({tag, "_rx_count"}, rx_count, 32'd0);
        checkOutput({tag, "_tx_count"}, tx_count, 32'd0);
        checkOutput({tag, "_drop_count"}, drop_count, 32'd0);
`endif
    endtask

    task automatic waitReply(input string tag);
        int n = 0;
        while ((got_frames < exp_frames) && (n < 4000)) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, "_reply_done"}, got_frames, exp_frames);
        checkOutput({tag, "_len"}, got.size(), exp_reply.size());
        for (int j = 0; j < exp_reply.size(); j++) begin
            if (j < got.size())
                checkOutput($sformatf("%s_byte%0d", tag, j), {23'd0, got_last[j], got[j]},
                            {23'd0, (j == exp_reply.size() - 1), exp_reply[j]});
        end
        checkOutput({tag, "_tuser"}, {31'd0, m_axis.tuser}, 32'd0);
        got.delete();
        got_last.delete();
        m_tx++;
    endtask

    task automatic expectNoReply(input string tag);
        repeat (20) @(posedge clk);
        #1;
        checkOutput({tag, "_no_reply"}, got_frames, exp_frames);
        checkOutput({tag, "_tvalid_idle"}, {31'd0, m_axis.tvalid}, 32'd0);
    endtask

    initial begin
        bit acc;
        int n;
        int kind;
        int len;
        logic [15:0] et;
        logic [7:0]  op;

        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = 8'h00;
        s_axis.tuser  = 3'b000;
        frm_bad       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        checkOutput("reset_tlast", {31'd0, m_axis.tlast}, 32'd0);
        checkOutput("reset_tdata", {24'd0, m_axis.tdata}, 32'd0);
        checkOutput("reset_tuser", {31'd0, m_axis.tuser}, 32'd0);
        checkCounters("reset");
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] basic 60-byte request");
        buildFrame(60, C_ETHERTYPE, 8'h01, 48'h020000000001);
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b0);
        waitReply("basic");
        checkOutput("basic_latency", first_valid_cyc - tlast_cyc, 32'd2);
        checkCounters("basic");

        $display("[TB] random tready stalls");
        tready_mode = 1;
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b1);
        waitReply("stall");
        checkCounters("stall");

        $display("[TB] request while reply stalled");
        tready_mode = 2;
        buildFrame(60, C_ETHERTYPE, 8'h01, 48'h020000000002);
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b0);
        n = 0;
        while (!m_axis.tvalid && (n < 20)) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("busy_reply_pending", {31'd0, m_axis.tvalid}, 32'd1);
        buildFrame(40, C_ETHERTYPE, 8'h01, 48'h020000000003);
        modelFrame(1'b1, 1'b1, acc);
        applyStimulus(1'b0);
        tready_mode = 1;
        buildFrame(60, C_ETHERTYPE, 8'h01, 48'h020000000002);
        waitReply("busy");
        checkCounters("busy");

        $display("[TB] rejected frames");
        tready_mode = 0;
        buildFrame(200, C_ETHERTYPE, 8'h01, 48'h020000000004);
        frm_bad = 1'b0;
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b0);
        expectNoReply("oversize");
        buildFrame(14, C_ETHERTYPE, 8'h01, 48'h020000000005);
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b0);
        expectNoReply("runt");
        buildFrame(60, C_ETHERTYPE, 8'h02, 48'h020000000006);
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b0);
        expectNoReply("opcode");
        buildFrame(60, C_ETHERTYPE, 8'h01, 48'h020000000007);
        frm_bad = 1'b1;
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b0);
        frm_bad = 1'b0;
        expectNoReply("bad_fcs");
        checkCounters("rejects");
        buildFrame(60, 16'h0800, 8'h01, 48'h020000000008);
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b0);
        expectNoReply("ipv4");
        checkCounters("ipv4");

        $display("[TB] enable low");
        enable = 1'b0;
        buildFrame(60, C_ETHERTYPE, 8'h01, 48'h020000000009);
        modelFrame(1'b0, 1'b0, acc);
        applyStimulus(1'b0);
        expectNoReply("disabled");
        checkCounters("disabled");
        enable = 1'b1;

        $display("[TB] random frame mix");
        for (int k = 0; k < 8; k++) begin
            kind = $urandom_range(0, 4);
            len  = $urandom_range(15, C_MAX_FRAME);
            et   = C_ETHERTYPE;
            op   = 8'h01;
            frm_bad = 1'b0;
            case (kind)
                2:       op = 8'($urandom_range(2, 255));
                3:       et = 16'($urandom_range(0, 16'h4C53));
                4:       frm_bad = 1'b1;
                default: ;
            endcase
            tready_mode = $urandom_range(0, 1);
            buildFrame(len, et, op, {16'($urandom), 32'($urandom)});
            modelFrame(1'b1, 1'b0, acc);
            applyStimulus(1'($urandom_range(0, 1)));
            if (acc) waitReply($sformatf("rand%0d", k));
            else     expectNoReply($sformatf("rand%0d", k));
            checkCounters($sformatf("rand%0d", k));
        end
        frm_bad = 1'b0;

        $display("[TB] reset during reply");
        tready_mode = 1;
        buildFrame(60, C_ETHERTYPE, 8'h01, 48'h02000000000A);
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b0);
        n = 0;
        while ((got.size() < 20) && (n < 2000)) begin
            @(posedge clk);
            n++;
        end
        checkOutput("rst_reached_byte20", {31'd0, (got.size() >= 20)}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        m_rx = 0;
        m_tx = 0;
        m_drop = 0;
        checkOutput("rst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        checkCounters("rst");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        got.delete();
        got_last.delete();
        exp_frames = got_frames;
        tready_mode = 0;
        repeat (2) @(posedge clk);
        buildFrame(60, C_ETHERTYPE, 8'h01, 48'h02000000000B);
        modelFrame(1'b1, 1'b0, acc);
        applyStimulus(1'b0);
        waitReply("post_rst");
        checkOutput("post_rst_latency", first_valid_cyc - tlast_cyc, 32'd2);
        checkCounters("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
